// File: rtl/ula_pkg.sv
// Shared types and constants for the ALU writeback stage.
// The entry widths here must match the BITS/AW parameters of ula_writeback.
package ula_pkg;

   localparam int WB_BITS = 16;
   localparam int WB_AW   = 4;

   localparam logic [1:0] FMT_ALU   = 2'b10;
   localparam logic [1:0] CLS_ARITH = 2'b00;

   localparam int FLG_O = 3;
   localparam int FLG_C = 2;
   localparam int FLG_S = 1;
   localparam int FLG_Z = 0;

   typedef struct packed {
      logic [WB_BITS-1:0] resu;
      logic               o;
      logic               c;
      logic               s;
      logic               z;
      logic [7:0]         op;
      logic               wb_en;
      logic [WB_AW-1:0]   waddr;
   } wb_entry_t;

   // Arithmetic ops commit all flags, logic ops clear O/C, constant ops leave flags alone.
   function automatic logic [3:0] commit_flags(input wb_entry_t e, input logic [3:0] cur);
      logic [3:0] nxt;
      nxt = cur;
      if (e.op[7:6] == FMT_ALU) begin
         if (e.op[4:3] == CLS_ARITH) begin
            nxt[FLG_O] = e.o;
            nxt[FLG_C] = e.c;
         end else begin
            nxt[FLG_O] = 1'b0;
            nxt[FLG_C] = 1'b0;
         end
         nxt[FLG_S] = e.s;
         nxt[FLG_Z] = e.z;
      end else begin
         nxt = cur;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ula_wb_fifo.sv
// In-order storage for writeback entries; exposes every slot in age order
// (index 0 = head) so the forwarding scan can pick the youngest match.
module ula_wb_fifo
   import ula_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  wb_entry_t        wr_entry,
   output logic [PW:0]      count,
   output wb_entry_t        view [DEPTH],
   output logic [DEPTH-1:0] vis
);

   localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [PW:0]   CNT_ONE = {{PW{1'b0}}, 1'b1};

   wb_entry_t     mem_r [DEPTH];
   logic [PW-1:0] rd_r;
   logic [PW-1:0] wr_r;
   logic [PW:0]   count_r;

   // Pointer and occupancy bookkeeping; flush empties the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_r    <= '0;
         wr_r    <= '0;
         count_r <= '0;
      end else if (flush) begin
         rd_r    <= '0;
         wr_r    <= '0;
         count_r <= '0;
      end else begin
         if (push) wr_r <= wr_r + PTR_ONE;
         if (pop)  rd_r <= rd_r + PTR_ONE;
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      end else if (push && !flush) begin
         mem_r[wr_r] <= wr_entry;
      end
   end

   // Age-ordered view of the buffer.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         view[k] = mem_r[rd_r + PW'(k)];
         vis[k]  = ((PW+1)'(k) < count_r);
      end
   end

   assign count = count_r;

endmodule

// File: rtl/ula_writeback.sv
// ALU writeback stage: buffers results, drives the register-file write port,
// commits architectural flags at retirement and answers forwarding queries.
module ula_writeback
   import ula_pkg::*;
#(
   parameter int BITS  = 16,
   parameter int DEPTH = 2,
   parameter int AW    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] in_resu,
   input  logic            in_o,
   input  logic            in_c,
   input  logic            in_s,
   input  logic            in_z,
   input  logic [7:0]      in_op,
   input  logic            in_wb_en,
   input  logic [AW-1:0]   in_waddr,
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [BITS-1:0] rf_wdata,
   input  logic            rf_grant,
   input  logic            flush,
   output logic [3:0]      flags,
   input  logic [AW-1:0]   q_addr,
   output logic            q_hit,
   output logic [BITS-1:0] q_data,
   output logic [15:0]     retire_cnt
);

   localparam int          PW      = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [PW:0]      count_s;
   wb_entry_t        view_s [DEPTH];
   logic [DEPTH-1:0] vis_s;
   wb_entry_t        in_entry_s;
   wb_entry_t        head_s;
   logic             head_valid_s;
   logic             push_s;
   logic             retire_s;
   logic             q_hit_s;
   logic [BITS-1:0]  q_data_s;
   logic [3:0]       flags_r;
   logic [15:0]      retire_cnt_r;

   assign in_entry_s = '{resu: in_resu, o: in_o, c: in_c, s: in_s, z: in_z,
                         op: in_op, wb_en: in_wb_en, waddr: in_waddr};

   // No pass-through when full: readiness looks at occupancy only.
   assign in_ready     = (count_s < DEPTH_C);
   assign push_s       = in_valid && in_ready && !flush;
   assign head_s       = view_s[0];
   assign head_valid_s = vis_s[0];
   assign retire_s     = head_valid_s && (!head_s.wb_en || rf_grant);

   ula_wb_fifo #(.DEPTH(DEPTH), .PW(PW)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push_s),
      .pop      (retire_s),
      .flush    (flush),
      .wr_entry (in_entry_s),
      .count    (count_s),
      .view     (view_s),
      .vis      (vis_s)
   );

   assign rf_we    = head_valid_s && head_s.wb_en;
   assign rf_waddr = head_s.waddr;
   assign rf_wdata = head_s.resu;

   // Architectural flag and retirement-count update; a retire in a flush cycle still counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r      <= 4'b0000;
         retire_cnt_r <= 16'h0000;
      end else if (retire_s) begin
         flags_r      <= commit_flags(head_s, flags_r);
         retire_cnt_r <= retire_cnt_r + 16'h0001;
      end
   end

   assign flags      = flags_r;
   assign retire_cnt = retire_cnt_r;

   // Forwarding scan from oldest to youngest so the youngest match wins.
   always_comb begin
      q_hit_s  = 1'b0;
      q_data_s = '0;
      for (int k = 0; k < DEPTH; k++) begin
         q_hit_s  = q_hit_s | (vis_s[k] && view_s[k].wb_en && (view_s[k].waddr == q_addr));
         q_data_s = (vis_s[k] && view_s[k].wb_en && (view_s[k].waddr == q_addr))
                    ? view_s[k].resu : q_data_s;
      end
   end

   assign q_hit  = q_hit_s;
   assign q_data = q_data_s;

endmodule

// File: tb/tb_ula_writeback.sv
// Directed, table-driven bench for ula_writeback plus hand-written flush,
// counter-wrap and asynchronous-reset sequences.
module tb_ula_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_resu;
   logic        in_o, in_c, in_s, in_z;
   logic [7:0]  in_op;
   logic        in_wb_en;
   logic [3:0]  in_waddr;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        rf_grant;
   logic        flush;
   logic [3:0]  flags;
   logic [3:0]  q_addr;
   logic        q_hit;
   logic [15:0] q_data;
   logic [15:0] retire_cnt;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   ula_writeback #(.BITS(16), .DEPTH(2), .AW(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_resu(in_resu), .in_o(in_o), .in_c(in_c), .in_s(in_s), .in_z(in_z),
      .in_op(in_op), .in_wb_en(in_wb_en), .in_waddr(in_waddr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_grant(rf_grant),
      .flush(flush), .flags(flags), .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data),
      .retire_cnt(retire_cnt)
   );

   typedef struct {
      logic        vld;
      logic [15:0] resu;
      logic [3:0]  fl;
      logic [7:0]  op;
      logic        wb;
      logic [3:0]  wa;
      logic        gnt;
      logic [3:0]  qa;
      logic        e_rdy;
      logic        e_we;
      logic [3:0]  e_wa;
      logic [15:0] e_wd;
      logic        e_hit;
      logic [15:0] e_qd;
      logic [3:0]  e_fl;
      logic [15:0] e_rc;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t mk(input logic vld, input logic [15:0] resu, input logic [3:0] fl,
                               input logic [7:0] op, input logic wb, input logic [3:0] wa,
                               input logic gnt, input logic [3:0] qa, input logic e_rdy,
                               input logic e_we, input logic [3:0] e_wa, input logic [15:0] e_wd,
                               input logic e_hit, input logic [15:0] e_qd, input logic [3:0] e_fl,
                               input logic [15:0] e_rc);
      vec_t v;
      v.vld = vld; v.resu = resu; v.fl = fl; v.op = op; v.wb = wb; v.wa = wa;
      v.gnt = gnt; v.qa = qa; v.e_rdy = e_rdy; v.e_we = e_we; v.e_wa = e_wa;
      v.e_wd = e_wd; v.e_hit = e_hit; v.e_qd = e_qd; v.e_fl = e_fl; v.e_rc = e_rc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [15:0] resu, input logic [3:0] fl,
                        input logic [7:0] op, input logic wb, input logic [3:0] wa,
                        input logic gnt, input logic fl_sh, input logic [3:0] qa);
      in_valid = vld; in_resu = resu; {in_o, in_c, in_s, in_z} = fl;
      in_op = op; in_wb_en = wb; in_waddr = wa; rf_grant = gnt; flush = fl_sh; q_addr = qa;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // vld resu  {ocsz}  op    wb wa  gnt qa     rdy we wa  wdata   hit qdata   flags   rcnt
      tbl[0]  = mk(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 4'b0000, 16'd0);
      tbl[1]  = mk(1'b1, 16'h8000, 4'b1110, 8'h80, 1'b1, 4'h3, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 4'b0000, 16'd0);
      tbl[2]  = mk(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b1, 4'h3, 1'b1, 1'b1, 4'h3, 16'h8000, 1'b1, 16'h8000, 4'b0000, 16'd0);
      tbl[3]  = mk(1'b1, 16'h00FF, 4'b1101, 8'h98, 1'b1, 4'h2, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 4'b1110, 16'd1);
      tbl[4]  = mk(1'b1, 16'h1234, 4'b0000, 8'h40, 1'b1, 4'h4, 1'b1, 4'hF, 1'b1, 1'b1, 4'h2, 16'h00FF, 1'b0, 16'h0000, 4'b1110, 16'd1);
      tbl[5]  = mk(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1, 4'h4, 16'h1234, 1'b0, 16'h0000, 4'b0001, 16'd2);
      tbl[6]  = mk(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 4'b0001, 16'd3);
      tbl[7]  = mk(1'b1, 16'h1111, 4'b0001, 8'h80, 1'b1, 4'h5, 1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 4'b0001, 16'd3);
      tbl[8]  = mk(1'b1, 16'h2222, 4'b0100, 8'h80, 1'b1, 4'h5, 1'b0, 4'h5, 1'b1, 1'b1, 4'h5, 16'h1111, 1'b1, 16'h1111, 4'b0001, 16'd3);
      tbl[9]  = mk(1'b1, 16'h3333, 4'b1010, 8'h80, 1'b1, 4'h6, 1'b0, 4'h5, 1'b0, 1'b1, 4'h5, 16'h1111, 1'b1, 16'h2222, 4'b0001, 16'd3);
      tbl[10] = mk(1'b1, 16'h3333, 4'b1010, 8'h80, 1'b1, 4'h6, 1'b0, 4'h6, 1'b0, 1'b1, 4'h5, 16'h1111, 1'b0, 16'h0000, 4'b0001, 16'd3);
      tbl[11] = mk(1'b1, 16'h3333, 4'b1010, 8'h80, 1'b1, 4'h6, 1'b1, 4'h5, 1'b0, 1'b1, 4'h5, 16'h1111, 1'b1, 16'h2222, 4'b0001, 16'd3);
      tbl[12] = mk(1'b1, 16'h3333, 4'b1010, 8'h80, 1'b1, 4'h6, 1'b0, 4'hF, 1'b1, 1'b1, 4'h5, 16'h2222, 1'b0, 16'h0000, 4'b0001, 16'd4);
      tbl[13] = mk(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1, 4'h5, 16'h2222, 1'b0, 16'h0000, 4'b0001, 16'd4);
      tbl[14] = mk(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1, 4'h6, 16'h3333, 1'b0, 16'h0000, 4'b0100, 16'd5);
      tbl[15] = mk(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 4'b1010, 16'd6);
      tbl[16] = mk(1'b1, 16'h0000, 4'b0001, 8'h80, 1'b0, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 4'b1010, 16'd6);
      tbl[17] = mk(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b0, 4'h1, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 4'b1010, 16'd6);
      tbl[18] = mk(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 4'b0001, 16'd7);

      rst_n = 1'b0;
      drive(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'hF);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Checks happen just before each edge, against pre-edge state and current inputs.
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].vld, tbl[i].resu, tbl[i].fl, tbl[i].op, tbl[i].wb, tbl[i].wa,
               tbl[i].gnt, 1'b0, tbl[i].qa);
         #1;
         chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(tbl[i].e_we));
         if (tbl[i].e_we) begin
            chk($sformatf("v%0d rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_wa));
            chk($sformatf("v%0d rf_wdata", i), 32'(rf_wdata), 32'(tbl[i].e_wd));
         end
         chk($sformatf("v%0d q_hit", i), 32'(q_hit), 32'(tbl[i].e_hit));
         chk($sformatf("v%0d q_data", i), 32'(q_data), 32'(tbl[i].e_qd));
         chk($sformatf("v%0d flags", i), 32'(flags), 32'(tbl[i].e_fl));
         chk($sformatf("v%0d retire_cnt", i), 32'(retire_cnt), 32'(tbl[i].e_rc));
         tick();
      end

      // Flush with two entries buffered, grant high and a competing input.
      drive(1'b1, 16'hAAAA, 4'b1111, 8'h80, 1'b1, 4'h7, 1'b0, 1'b0, 4'hF);
      tick();
      drive(1'b1, 16'hBBBB, 4'b0010, 8'h80, 1'b1, 4'h8, 1'b0, 1'b0, 4'hF);
      tick();
      drive(1'b1, 16'hCCCC, 4'b0000, 8'h80, 1'b1, 4'h9, 1'b1, 1'b1, 4'h9);
      #1;
      chk("flush head we", 32'(rf_we), 32'd1);
      chk("flush head waddr", 32'(rf_waddr), 32'h7);
      chk("flush head wdata", 32'(rf_wdata), 32'hAAAA);
      tick();
      drive(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 4'h9);
      #1;
      chk("post-flush rf_we", 32'(rf_we), 32'd0);
      chk("post-flush in_ready", 32'(in_ready), 32'd1);
      chk("post-flush q_hit dropped input", 32'(q_hit), 32'd0);
      chk("post-flush flags", 32'(flags), 32'hF);
      chk("post-flush retire_cnt", 32'(retire_cnt), 32'd8);
      tick();
      #1;
      chk("post-flush idle retire_cnt", 32'(retire_cnt), 32'd8);

      // Flag-only constant ops retire one per cycle without a grant until the counter wraps.
      drive(1'b1, 16'h0000, 4'b1111, 8'h40, 1'b0, 4'h0, 1'b0, 1'b0, 4'hF);
      repeat (65527) @(posedge clk);
      #2;
      drive(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'hF);
      repeat (3) tick();
      #1;
      chk("retire_cnt at max", 32'(retire_cnt), 32'hFFFF);
      chk("flags kept by constant ops", 32'(flags), 32'hF);
      drive(1'b1, 16'h0000, 4'b0000, 8'h40, 1'b0, 4'h0, 1'b0, 1'b0, 4'hF);
      tick();
      drive(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'hF);
      repeat (2) tick();
      #1;
      chk("retire_cnt wrap", 32'(retire_cnt), 32'h0000);

      // Asynchronous reset between edges with a stalled write pending.
      drive(1'b1, 16'h5555, 4'b1111, 8'h80, 1'b1, 4'h2, 1'b0, 1'b0, 4'h2);
      tick();
      drive(1'b0, 16'h0000, 4'b0000, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h2);
      #1;
      chk("pre-reset rf_we", 32'(rf_we), 32'd1);
      chk("pre-reset q_hit", 32'(q_hit), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async reset flags", 32'(flags), 32'h0);
      chk("async reset rf_we", 32'(rf_we), 32'd0);
      chk("async reset q_hit", 32'(q_hit), 32'd0);
      chk("async reset retire_cnt", 32'(retire_cnt), 32'h0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("after reset in_ready", 32'(in_ready), 32'd1);
      chk("after reset rf_we", 32'(rf_we), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ula_writeback.md
Name: ula_writeback

Overview:
- Writeback stage directly downstream of the 16-bit ALU (AR/LO/constant unit).
- Captures each ALU result with its flags O, C, S and Z, the op code and the destination register.
- Buffers results in a small in-order FIFO and drives the register-file write port, which may stall via a grant.
- Commits the architectural flag register at retirement and provides a forwarding lookup for operand bypass.

Parameters:
- BITS, 16, data width; must match the ALU width.
- DEPTH, 2, number of buffer entries; must be a power of two, at least 2.
- AW, 4, register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  buffer can accept a result.
- in_resu  in  BITS  ALU result (RESU).
- in_o, in_c, in_s, in_z  in  1 each  ALU flags.
- in_op  in  8  op code: [7:6] format, [5] R, [4:0] operation.
- in_wb_en  in  1  result is written to the register file (0 = flag-only op, e.g. compare).
- in_waddr  in  AW  destination register.
- rf_we  out  1  register-file write request.
- rf_waddr  out  AW  write address.
- rf_wdata  out  BITS  write data.
- rf_grant  in  1  write port granted this cycle.
- flush  in  1  synchronous discard of all buffered entries.
- flags  out  4  architectural flags {O,C,S,Z}.
- q_addr  in  AW  forwarding query address.
- q_hit  out  1  a buffered entry targets q_addr.
- q_data  out  BITS  data for q_hit.
- retire_cnt  out  16  count of retired entries.

Behaviour:
- Reset (rst_n low, asynchronous): count, pointers, flags and retire_cnt = 0. rf_we = 0, q_hit = 0, in_ready = 1 once reset is released.
- Accept: on in_valid && in_ready at a rising edge, store {resu, o, c, s, z, op, wb_en, waddr} at the tail.
- in_ready = (count < DEPTH). It depends on count only; there is no same-cycle pass-through when full, even if the head retires that cycle.
- Latency: a result accepted at edge N is at the head and visible on rf_* at the earliest in cycle N+1.
- Head presentation (combinational from the head entry):
  - rf_we = head_valid && head.wb_en.
  - rf_waddr and rf_wdata come from the head entry.
  - rf_wdata holds stable while rf_we is high and rf_grant is low.
- Retire condition: head_valid && (!head.wb_en || rf_grant). A flag-only entry retires without a grant, one per cycle.
- Flag commit at retire, strictly in order:
  - op[7:6]==2'b10 and op[4:3]==2'b00 (arithmetic): flags <= {o,c,s,z}.
  - op[7:6]==2'b10 and op[4:3]!=2'b00 (logic): flags <= {0,0,s,z}.
  - op[7:6]!=2'b10 (constant format): flags unchanged.
- retire_cnt increments by 1 per retirement and wraps 0xFFFF -> 0x0000.
- Simultaneous accept and retire when not full: count unchanged, both pointers advance.
- Pointer wrap: modulo DEPTH. Count distinguishes full from empty.
- flush:
  - At the edge, count and pointers go to 0.
  - A retirement qualified in the same cycle still commits its flags, retire_cnt increment and register write (the grant is honoured).
  - flush beats in_valid: an accept in the flush cycle is dropped.
  - flags are not otherwise affected.
- Forwarding:
  - q_hit = some valid entry has wb_en==1 && waddr==q_addr.
  - q_data comes from the youngest such entry.
  - The head entry still matches during its retire cycle.
  - q_data = 0 when there is no hit.
- Reset asserted mid-operation: all buffered entries are lost and flags clear immediately, without waiting for clk.

Decomposition:
- Package ula_pkg:
  - Format constant FMT_ALU = 2'b10 and class constant CLS_ARITH = 2'b00.
  - Packed struct wb_entry_t {resu, o, c, s, z, op, wb_en, waddr}.
  - Flag index constants FLG_O=3, FLG_C=2, FLG_S=1, FLG_Z=0.
- One natural sub-module: ula_wb_fifo, a DEPTH-entry storage holding wb_entry_t with push, pop, flush, count and per-entry visibility for the forwarding scan.

Test Plan:
- Push {resu=0x8000, op=0x80, o=1,c=1,s=1,z=0, wb_en=1, waddr=3} with rf_grant=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x8000; after the retire edge flags=4'b1110 and retire_cnt=1.
- Push logic op op=0x98 (s=0, z=1, o=1, c=1) -> flags=4'b0001; then push constant op op=0x40 with z=0 -> flags stay 4'b0001.
- Hold rf_grant=0 and push 3 results -> in_ready=0 after 2 accepts; the 3rd is held upstream; rf_wdata stays equal to the first result until grant; then all 3 retire in order.
- Push waddr=5 data 0x1111 then waddr=5 data 0x2222, grant low, q_addr=5 -> q_hit=1, q_data=0x2222; q_addr=6 -> q_hit=0, q_data=0.
- With 2 entries buffered, assert flush with rf_grant=1 and in_valid=1 -> exactly one write (head) occurs, the new input is dropped, count=0 next cycle, retire_cnt+1.
- Preload retire_cnt to 0xFFFF via 65535 flag-only retirements, retire one more -> 0x0000. Assert rst_n low asynchronously between edges -> flags=0, rf_we=0 immediately.
